vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
VGA 640x480@60 Hz raster timing generator that sits directly upstream of the pixel address generator. It divides the system clock down to a pixel tick and runs the horizontal and vertical position counters. It produces active-low hsync/vsync, a visible-region flag and a frame-start pulse. hor_reg/ver_reg feed the address generator's horReg/verReg inputs unchanged; visible-region bounds match that stage (H 111..751, V 11..491).

Parameters:
CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal values are 1..16.
H_TOTAL, 800, pixel ticks per line.
H_SYNC, 96, hsync pulse width in ticks, at counts 0..H_SYNC-1.
H_VIS_START, 111, first visible horizontal count.
H_VIS_END, 751, first non-visible horizontal count after the active region.
V_TOTAL, 525, lines per frame.
V_SYNC, 2, vsync pulse width in lines, at lines 0..V_SYNC-1.
V_VIS_START, 11, first visible line.
V_VIS_END, 491, first non-visible line after the active region.

Ports:
clock  input  1  system clock, all logic rising-edge.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  run/freeze control.
hor_reg  output  11  horizontal count, 0..H_TOTAL-1.
ver_reg  output  10  vertical count, 0..V_TOTAL-1.
pix_tick  output  1  one-clock strobe, once per pixel period.
hsync  output  1  horizontal sync, active low.
vsync  output  1  vertical sync, active low.
visible  output  1  high inside the active 640x480 region.
frame_start  output  1  one-clock pulse when the raster wraps to (0,0).

Behaviour:
- Reset: one clock, reset is asynchronous and active-low (clock / reset_n). While reset_n=0, all state clears immediately:
  - divider=0, hor_reg=0, ver_reg=0
  - pix_tick=0, frame_start=0, visible=0
  - hsync=0 and vsync=0, because count (0,0) lies inside both sync pulses.
- Reset mid-frame: takes effect immediately, no completion of the current line.
- All outputs are registered. hsync, vsync and visible always equal the decode of the current hor_reg/ver_reg. Implement this by decoding the next-count values, not by lagging one clock.
- Divider: counts 0..CLK_DIV-1 while enable=1.
  - On the edge where it wraps to 0, pix_tick is registered high for exactly one clock and the counters advance on that same edge.
  - First pix_tick after reset release occurs on the CLK_DIV-th rising edge; hor_reg becomes 1 on that edge.
  - CLK_DIV=1: pix_tick stays high every clock while enable=1; counters advance every clock.
- Horizontal counter: increments per tick; H_TOTAL-1 -> 0.
- Vertical counter: increments only when hor_reg wraps; V_TOTAL-1 -> 0 on the same edge.
- frame_start: high for exactly the one clock in which (hor_reg,ver_reg) becomes (0,0) by wrap. It is never asserted by reset.
- Decode rules:
  - hsync = 0 iff hor_reg < H_SYNC.
  - vsync = 0 iff ver_reg < V_SYNC.
  - visible = 1 iff H_VIS_START <= hor_reg < H_VIS_END and V_VIS_START <= ver_reg < V_VIS_END.
- enable=0:
  - Divider and counters hold.
  - pix_tick=0 and frame_start=0 from the next edge.
  - hsync, vsync and visible hold their decoded values.
  - Re-enable resumes from the held divider phase; no skipped or extra ticks.
- Widths: compare in the full counter widths (11 b horizontal, 10 b vertical). Parameter values must fit those widths; an elaboration-time check flags H_TOTAL > 2048 or V_TOTAL > 1024.

Decomposition:
- Shared package vga_pkg holds the timing constants (H_*, V_*), the counter width constants HW=11 and VW=10, and typedefs hcount_t and vcount_t. The downstream address stage imports the same constants.
- One sub-module, pix_tick_gen: the CLK_DIV divider with enable, producing the registered pix_tick.
- Counters and sync/visible decode stay in vga_sync_gen.

Test Plan:
1. Reset release, CLK_DIV=2, enable=1 -> pix_tick high on clocks 2,4,6,...; hor_reg=1 at clock 2, hor_reg=5 at clock 10; hsync=0, vsync=0, visible=0.
2. Run one line -> hsync rises when hor_reg goes 95->96. visible stays 0 on line 0; on line 11, visible rises at hor 111 and falls at hor 751. hor 799->0 increments ver_reg.
3. Run full frame -> vsync low only for lines 0-1. Visible ticks total 640 x 480 = 307200. frame_start pulses once at the 420000th tick (800 x 525), coincident with pix_tick, and the counters read (0,0).
4. Drop enable for 7 clocks at hor=300, ver=20 -> counters and visible hold, pix_tick=0. After re-enable, the next tick gives hor=301 with no skipped count.
5. Assert reset_n=0 asynchronously between edges at hor=600, ver=400 -> outputs clear immediately without a clock edge (hsync=0, vsync=0, visible=0); frame_start stays 0.
6. CLK_DIV=1 -> pix_tick is constantly 1; the line period is 800 clocks and the frame period is 420000 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants, count types and window helpers
package vga_pkg;

  localparam int HW = 11;
  localparam int VW = 10;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_VIS_START = 111;
  localparam int H_VIS_END   = 751;

  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 11;
  localparam int V_VIS_END   = 491;

  typedef logic [HW-1:0] hcount_t;
  typedef logic [VW-1:0] vcount_t;

  // Half-open window test [lo, hi) done in the full counter width.
  function automatic logic h_in_window(input hcount_t pos, input hcount_t lo, input hcount_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  function automatic logic v_in_window(input vcount_t pos, input vcount_t lo, input vcount_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - system clock to pixel tick divider with run/freeze control
// step is the combinational "tick happens on this edge"; pix_tick is its registered copy.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic step,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pix_tick_gen: CLK_DIV must be 1..16");
  end

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap = (div == DW'(CLK_DIV - 1));
  assign step = enable && wrap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      if (enable) begin
        div <= wrap ? '0 : div + 1'b1;
      end
      pix_tick <= step;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters with registered sync, visible and frame-start
// Decode works on the next-count values so sync/visible line up with hor_reg/ver_reg.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_VIS_START = vga_pkg::H_VIS_START,
  parameter int H_VIS_END   = vga_pkg::H_VIS_END,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_VIS_START = vga_pkg::V_VIS_START,
  parameter int V_VIS_END   = vga_pkg::V_VIS_END
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic [HW-1:0] hor_reg,
  output logic [VW-1:0] ver_reg,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic          frame_start
);

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit the counter widths");
  end

  logic    step;
  logic    wrap_h;
  logic    wrap_v;
  hcount_t hor_nxt;
  vcount_t ver_nxt;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .step     (step),
    .pix_tick (pix_tick)
  );

  assign wrap_h = (hor_reg == hcount_t'(H_TOTAL - 1));
  assign wrap_v = (ver_reg == vcount_t'(V_TOTAL - 1));

  always_comb begin
    hor_nxt = hor_reg;
    ver_nxt = ver_reg;
    if (step) begin
      hor_nxt = wrap_h ? '0 : hor_reg + 1'b1;
      if (wrap_h) begin
        ver_nxt = wrap_v ? '0 : ver_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hor_reg     <= '0;
      ver_reg     <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      visible     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hor_reg     <= hor_nxt;
      ver_reg     <= ver_nxt;
      hsync       <= (hor_nxt >= hcount_t'(H_SYNC));
      vsync       <= (ver_nxt >= vcount_t'(V_SYNC));
      visible     <= h_in_window(hor_nxt, hcount_t'(H_VIS_START), hcount_t'(H_VIS_END)) &&
                     v_in_window(ver_nxt, vcount_t'(V_VIS_START), vcount_t'(V_VIS_END));
      frame_start <= step && wrap_h && wrap_v;
    end
  end

endmodule
